// File: rtl/mem_serial_loader.sv
// mem_serial_loader
// Receives a serial boot frame (CMD, ADDR, LEN, data bytes, CHK) and writes
// the data bytes into program memory one byte per m_we strobe. A frame whose
// XOR checksum matches ends in DONE and can kick the serial CPU. A bad command
// byte, a checksum mismatch or an early drop of ser_en ends the frame with err.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | between frames; the first accepted bit starts a new frame
// CMD    | collecting the command byte (magic nibble + addr[8])
// ADDR   | collecting addr[7:0]
// LEN    | collecting the byte count (0 encodes 256)
// DATA   | collecting data bytes; each completed byte is written to memory
// CHK    | collecting the checksum byte
// DONE   | good frame; serial input ignored until ser_en falls
// ERR    | bad command or checksum; serial input ignored until ser_en falls
module mem_serial_loader #(
  parameter int         ADDR_WIDTH = 9,
  parameter logic [3:0] MAGIC      = 4'hA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_en,
  input  logic                  ser_vld,
  input  logic                  ser_din,
  input  logic                  auto_start,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [7:0]            m_datain,
  output logic                  m_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_start
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q;
  logic [6:0]            shift_q;
  logic                  addr_hi_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [8:0]            cnt_q;
  logic [7:0]            chk_q;

  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [7:0]            m_datain_q;
  logic                  m_we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  cpu_start_q;

  logic                  in_frame;
  logic                  bit_acc;
  logic                  byte_done;
  logic                  cmd_ok;
  logic                  chk_ok;
  logic                  wr_d;
  logic [7:0]            byte_w;

  // Bit acceptance and byte assembly; byte_w already includes the current bit.
  always_comb begin
    in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_LEN) ||
                (state_q == S_DATA) || (state_q == S_CHK);
    bit_acc   = ser_en & ser_vld & (in_frame | (state_q == S_IDLE));
    byte_w    = {shift_q, ser_din};
    byte_done = in_frame & bit_acc & (bit_cnt_q == 3'd7);
    cmd_ok    = (byte_w[7:4] == MAGIC) && (byte_w[3:1] == 3'b000);
    chk_ok    = (byte_w == chk_q);
    wr_d      = byte_done & (state_q == S_DATA);
  end

  // Next-state decode; dropping ser_en inside a frame always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ser_en && ser_vld) state_d = S_CMD;
      S_CMD:
        if (!ser_en)        state_d = S_IDLE;
        else if (byte_done) state_d = cmd_ok ? S_ADDR : S_ERR;
      S_ADDR:
        if (!ser_en)        state_d = S_IDLE;
        else if (byte_done) state_d = S_LEN;
      S_LEN:
        if (!ser_en)        state_d = S_IDLE;
        else if (byte_done) state_d = S_DATA;
      S_DATA:
        if (!ser_en)        state_d = S_IDLE;
        else if (byte_done && (cnt_q == 9'd1)) state_d = S_CHK;
      S_CHK:
        if (!ser_en)        state_d = S_IDLE;
        else if (byte_done) state_d = chk_ok ? S_DONE : S_ERR;
      S_DONE:  if (!ser_en) state_d = S_IDLE;
      S_ERR:   if (!ser_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      addr_hi_q   <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= 9'd0;
      chk_q       <= 8'd0;
      m_addr_q    <= '0;
      m_datain_q  <= 8'd0;
      m_we_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_we_q      <= wr_d;
      cpu_start_q <= 1'b0;
      busy_q      <= (state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_LEN) ||
                     (state_d == S_DATA) || (state_d == S_CHK) || wr_d;

      if (state_q == S_IDLE) begin
        if (bit_acc) begin
          // The starting bit is the MSB of the command byte.
          bit_cnt_q <= 3'd1;
          shift_q   <= {6'd0, ser_din};
          chk_q     <= 8'd0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
        end
      end else if (in_frame && !ser_en) begin
        // Abort: the partial byte is dropped, completed writes stand.
        bit_cnt_q <= 3'd0;
        err_q     <= 1'b1;
      end else if (bit_acc) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= byte_w[6:0];
      end

      if (byte_done) begin
        case (state_q)
          S_CMD: begin
            if (cmd_ok) addr_hi_q <= byte_w[0];
            else        err_q     <= 1'b1;
          end
          S_ADDR: addr_q <= ADDR_WIDTH'({addr_hi_q, byte_w});
          S_LEN:  cnt_q  <= (byte_w == 8'd0) ? 9'd256 : {1'b0, byte_w};
          S_DATA: begin
            m_addr_q   <= addr_q;
            m_datain_q <= byte_w;
            chk_q      <= chk_q ^ byte_w;
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            cnt_q      <= cnt_q - 9'd1;
          end
          S_CHK: begin
            if (chk_ok) begin
              done_q      <= 1'b1;
              cpu_start_q <= auto_start;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_addr    = m_addr_q;
  assign m_datain  = m_datain_q;
  assign m_we      = m_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_start = cpu_start_q;

endmodule

// File: tb/tb_mem_serial_loader.sv
// Bench for mem_serial_loader: frames are driven bit-serially with random
// strobe gaps; a frame-level reference model pushes expected memory writes
// into a scoreboard queue that a negedge monitor drains on every m_we.
module tb_mem_serial_loader;

  typedef logic [7:0] byteq_t[$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_en;
  logic       ser_vld;
  logic       ser_din;
  logic       auto_start;
  logic [8:0] m_addr;
  logic [7:0] m_datain;
  logic       m_we;
  logic       busy;
  logic       done;
  logic       err;
  logic       cpu_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cpu_cnt  = 0;

  logic [16:0] exp_q[$];
  logic [8:0]  last_addr = 9'd0;
  logic [7:0]  last_data = 8'd0;

  mem_serial_loader #(.ADDR_WIDTH(9), .MAGIC(4'hA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_en     (ser_en),
    .ser_vld    (ser_vld),
    .ser_din    (ser_din),
    .auto_start (auto_start),
    .m_addr     (m_addr),
    .m_datain   (m_datain),
    .m_we       (m_we),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_start  (cpu_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write pops one expected (addr,data); outside
  // writes the memory bus must hold the last written values.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (m_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", int'(m_addr), int'(e[16:8]));
          check("write_data", int'(m_datain), int'(e[7:0]));
          last_addr = e[16:8];
          last_data = e[7:0];
        end
      end else begin
        check("hold_addr", int'(m_addr), int'(last_addr));
        check("hold_data", int'(m_datain), int'(last_data));
      end
      if (cpu_start) cpu_cnt++;
    end
  end

  // Frame-level reference: decides the outcome from the byte list and how many
  // bits were sent before ser_en fell, and queues the writes that must happen.
  function automatic void model(input byteq_t b, input int nbits, input bit auto_s,
                                output bit e_done, output bit e_err,
                                output bit terminal, output int e_cpu);
    int nfull;
    int addr;
    int len;
    logic [7:0] x;
    logic [8:0] a9;
    nfull = nbits / 8;
    x = 8'd0;
    e_done = 1'b0;
    e_err = 1'b1;
    terminal = 1'b0;
    e_cpu = 0;
    if (nfull < 1) return;
    if (b[0][7:4] != 4'hA || b[0][3:1] != 3'b000) begin
      terminal = 1'b1;
      return;
    end
    if (nfull < 3) return;
    addr = int'(b[0][0]) * 256 + int'(b[1]);
    len = (b[2] == 8'd0) ? 256 : int'(b[2]);
    for (int i = 0; i < len; i++) begin
      if (3 + i >= nfull) return;
      a9 = addr[8:0];
      exp_q.push_back({a9, b[3+i]});
      x = x ^ b[3+i];
      addr = (addr + 1) % 512;
    end
    if (3 + len >= nfull) return;
    terminal = 1'b1;
    if (b[3+len] == x) begin
      e_done = 1'b1;
      e_err = 1'b0;
      e_cpu = auto_s ? 1 : 0;
    end
  endfunction

  task automatic send_bits(input byteq_t b, input int nbits);
    logic [7:0] cur;
    for (int i = 0; i < nbits; i++) begin
      cur = b[i/8];
      repeat ($urandom_range(0, 2)) begin
        ser_vld = 1'b0;
        ser_din = 1'($urandom);
        @(posedge clk); #1;
      end
      ser_vld = 1'b1;
      ser_din = cur[7 - (i % 8)];
      @(posedge clk); #1;
      ser_vld = 1'b0;
    end
  endtask

  task automatic idle_gap(input int cycles);
    ser_en = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      ser_vld = 1'($urandom);
      ser_din = 1'($urandom);
      @(posedge clk); #1;
    end
    ser_vld = 1'b0;
  endtask

  task automatic run_frame(input byteq_t b, input int nbits_in, input bit auto_s);
    bit e_done, e_err, terminal;
    int e_cpu;
    int nbits;
    nbits = (nbits_in < 0) ? b.size() * 8 : nbits_in;
    model(b, nbits, auto_s, e_done, e_err, terminal, e_cpu);
    cpu_cnt = 0;
    auto_start = auto_s;
    ser_en = 1'b1;
    send_bits(b, nbits);
    @(negedge clk);
    check("busy_at_end", int'(busy), terminal ? 0 : 1);
    check("done_at_end", int'(done), (terminal && e_done) ? 1 : 0);
    check("err_at_end", int'(err), (terminal && e_err) ? 1 : 0);
    check("cpu_start_timing", int'(cpu_start), terminal ? e_cpu : 0);
    if (nbits_in < 0) begin
      byteq_t junk;
      int nj;
      nj = int'($urandom_range(0, 5));
      for (int i = 0; i < nj; i++) junk.push_back(8'($urandom));
      @(posedge clk); #1;
      send_bits(junk, nj * 8);
    end
    idle_gap(3);
    @(negedge clk);
    check("done", int'(done), int'(e_done));
    check("err", int'(err), int'(e_err));
    check("busy_idle", int'(busy), 0);
    check("cpu_start_count", cpu_cnt, e_cpu);
    check("writes_outstanding", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_data();
    byteq_t b;
    bit d0, e0, t0;
    int c0;
    b = '{8'hA0, 8'h40, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01};
    model(b, 6 * 8 + 4, 1'b1, d0, e0, t0, c0);
    cpu_cnt = 0;
    auto_start = 1'b1;
    ser_en = 1'b1;
    send_bits(b, 6 * 8 + 4);
    #2 rst_n = 1'b0;
    last_addr = 9'd0;
    last_data = 8'd0;
    #1;
    check("rst_m_we", int'(m_we), 0);
    check("rst_m_addr", int'(m_addr), 0);
    check("rst_m_datain", int'(m_datain), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_cpu_start", int'(cpu_start), 0);
    check("rst_writes_outstanding", exp_q.size(), 0);
    repeat (3) begin
      ser_vld = 1'b1;
      ser_din = 1'($urandom);
      @(posedge clk);
      check("rst_no_write", int'(m_we), 0);
    end
    #1;
    ser_vld = 1'b0;
    ser_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy_after", int'(busy), 0);
  endtask

  initial begin
    byteq_t b;
    rst_n = 1'b0;
    ser_en = 1'b0;
    ser_vld = 1'b0;
    ser_din = 1'b0;
    auto_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_addr", int'(m_addr), 0);
    check("reset_m_datain", int'(m_datain), 0);
    check("reset_m_we", int'(m_we), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_cpu_start", int'(cpu_start), 0);
    rst_n = 1'b1;
    idle_gap(4);

    b = '{8'hA0, 8'h20, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_frame(b, -1, 1'b1);
    b = '{8'h50, 8'h11, 8'h22};
    run_frame(b, -1, 1'b1);
    b = '{8'hA1, 8'hFF, 8'h02, 8'h5A, 8'hA5, 8'hFF};
    run_frame(b, -1, 1'b0);
    b = '{8'hA0, 8'h10, 8'h01, 8'h77, 8'h00};
    run_frame(b, -1, 1'b1);
    b = '{8'hA0, 8'h30, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_frame(b, 4 * 8 + 3, 1'b1);
    b = '{8'hA0, 8'h20, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_frame(b, -1, 1'b1);

    reset_mid_data();
    b = '{8'hA0, 8'h50, 8'h02, 8'hC3, 8'h3C, 8'hFF};
    run_frame(b, -1, 1'b1);

    begin
      logic [7:0] x;
      x = 8'd0;
      b = '{8'hA1, 8'h80, 8'h00};
      for (int i = 0; i < 256; i++) begin
        b.push_back(8'($urandom));
        x = x ^ b[b.size()-1];
      end
      b.push_back(x);
      run_frame(b, -1, 1'b1);
    end

    for (int f = 0; f < 30; f++) begin
      logic [7:0] x;
      logic [7:0] cmd;
      int len;
      int total;
      x = 8'd0;
      cmd = 8'($urandom);
      if ($urandom_range(0, 9) != 0) cmd = {4'hA, 3'b000, cmd[0]};
      len = int'($urandom_range(1, 6));
      b = '{cmd, 8'($urandom), 8'(len)};
      for (int i = 0; i < len; i++) begin
        b.push_back(8'($urandom));
        x = x ^ b[b.size()-1];
      end
      if ($urandom_range(0, 9) < 3) x = x ^ 8'(1 << $urandom_range(0, 7));
      b.push_back(x);
      total = b.size() * 8;
      if ($urandom_range(0, 9) < 3)
        run_frame(b, int'($urandom_range(1, total - 1)), 1'($urandom));
      else
        run_frame(b, -1, 1'($urandom));
      idle_gap(int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_serial_loader.md
MEM_SERIAL_LOADER -- requirements
Module: mem_serial_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 9: memory byte-address width.
REQ-002 Parameter MAGIC, default 4'hA: required command-byte upper nibble.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ser_en  input  1  frame envelope; high for the whole frame, low between frames.
REQ-006 ser_vld  input  1  bit strobe; ser_din sampled on clk when ser_en=1 and ser_vld=1.
REQ-007 ser_din  input  1  serial data, MSB of each byte first.
REQ-008 auto_start  input  1  when 1, a good frame produces cpu_start.
REQ-009 m_addr  output  ADDR_WIDTH  memory write address.
REQ-010 m_datain  output  8  memory write data.
REQ-011 m_we  output  1  memory write strobe, one cycle per data byte.
REQ-012 busy  output  1  frame in progress; the integration gates CPU enable with ~busy.
REQ-013 done  output  1  sticky, last frame completed with good checksum.
REQ-014 err  output  1  sticky, last frame failed.
REQ-015 cpu_start  output  1  one-cycle start pulse to the serial CPU.

Function
REQ-016 Frame byte order SHALL be: CMD {MAGIC[3:0], 3'b000, addr[8]}, ADDR addr[7:0], LEN (0 means 256), LEN data bytes, CHK (XOR of all data bytes).
REQ-017 A 3-bit bit counter SHALL shift ser_din into a byte register and flag byte-complete on the 8th accepted bit.
REQ-018 FSM states SHALL be IDLE, CMD, ADDR, LEN, DATA, CHK, DONE, ERR.
REQ-019 IDLE->CMD SHALL occur on the first accepted bit while ser_en=1, clearing done, err, bit counter and checksum.
REQ-020 CMD byte-complete: upper nibble==MAGIC and bits[3:1]==0 -> ADDR with addr[8] latched; otherwise -> ERR with err=1.
REQ-021 ADDR byte-complete SHALL latch addr[7:0] -> LEN; LEN byte-complete SHALL load remaining count (0 -> 256) -> DATA.
REQ-022 DATA byte-complete SHALL, on the next clk edge, drive m_we=1 for exactly one cycle with m_addr=current address and m_datain=byte, XOR byte into checksum, increment address modulo 2^ADDR_WIDTH (0x1FF wraps to 0x000), decrement count.
REQ-023 DATA with count reaching 0 SHALL go to CHK; CHK byte-complete: match -> DONE with done=1, mismatch -> ERR with err=1.
REQ-024 Entering DONE with auto_start=1 SHALL produce cpu_start=1 for exactly one cycle, one cycle after the CHK byte completes; never otherwise.
REQ-025 DONE and ERR SHALL ignore ser_vld and return to IDLE when ser_en=0.
REQ-026 ser_en=0 in CMD, ADDR, LEN, DATA or CHK SHALL abort to IDLE with err=1; bytes already written stay written; a partial byte is discarded.
REQ-027 busy SHALL be 1 in CMD, ADDR, LEN, DATA, CHK, and during the pending m_we cycle; 0 otherwise.
REQ-028 ser_vld while ser_en=0 SHALL be ignored.
REQ-029 m_addr and m_datain SHALL hold their last values when m_we=0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, counters 0, m_addr 0, m_datain 0, m_we 0, busy 0, done 0, err 0, cpu_start 0, including mid-frame; no write completes after reset assertion.

Verification
REQ-031 Frame A0 20 03 11 22 33 00, auto_start=1 -> writes 0x020=11, 0x021=22, 0x022=33; three m_we pulses; done=1, err=0; one cpu_start pulse.
REQ-032 CMD byte 0x50 -> err=1, no m_we, busy=0 after ser_en falls.
REQ-033 Frame A1 FF 02 5A A5 FF -> writes 0x1FF=5A then 0x000=A5; done=1.
REQ-034 Frame A0 10 01 77 00, auto_start=1 -> 0x010=77 written; err=1, done=0, no cpu_start.
REQ-035 Frame A0 30 04 01, ser_en dropped after 3 bits of second data byte -> one write at 0x030=01, err=1, busy=0; next good frame clears err.
REQ-036 rst_n pulsed low mid-DATA -> all outputs 0 asynchronously, no further m_we; next frame loads normally.
